// File: rtl/instr_sequencer.sv
// Six-phase (T1..T6) control sequencer for the 8-bit W-register datapath.
// It drives the datapath load strobes, decodes GOTO/CALL/RETURN and keeps the return-address stack.
module instr_sequencer #(
    parameter int PC_W        = 11,
    parameter int IR_W        = 14,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            step,
    input  logic [IR_W-1:0] ir,
    input  logic [PC_W-1:0] pc,
    output logic            load_mar,
    output logic            load_pc,
    output logic            pc_src,
    output logic [PC_W-1:0] pc_target,
    output logic            load_ir,
    output logic            load_w,
    output logic            halted,
    output logic            illegal,
    output logic            stk_err,
    output logic [2:0]      state_dbg
);

    localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int DEP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [DEP_W-1:0] DEPTH_FULL = DEP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        T6   = 3'd6,
        HALT = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   stack_q [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [DEP_W-1:0]  depth_q, depth_d;
    logic              err_q, err_d;
    logic              push;

    logic [5:0]        op6;
    logic              is_alu, is_goto, is_call, is_ret, is_nop;
    logic              go;
    logic [SP_W-1:0]   top_idx;
    logic [PC_W-1:0]   jump_addr;

    assign op6       = ir[13:8];
    assign is_alu    = (op6 == 6'b110000) || (op6 == 6'b111110) || (op6 == 6'b111100) ||
                       (op6 == 6'b111001) || (op6 == 6'b111000) || (op6 == 6'b111010);
    assign is_goto   = (ir[13:11] == 3'b101);
    assign is_call   = (ir[13:11] == 3'b100);
    assign is_ret    = (ir == IR_W'(14'h0008));
    assign is_nop    = (ir == '0);
    // run and step only matter where an instruction boundary is decided (T0, T6, HALT).
    assign go        = run | step;
    assign top_idx   = sp_q - SP_W'(1);
    assign jump_addr = PC_W'(ir[10:0]);

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        depth_d   = depth_q;
        err_d     = err_q;
        push      = 1'b0;
        load_mar  = 1'b0;
        load_pc   = 1'b0;
        pc_src    = 1'b0;
        pc_target = '0;
        load_ir   = 1'b0;
        load_w    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            T0:   state_d = go ? T1 : HALT;
            T1: begin
                load_mar = 1'b1;
                state_d  = T2;
            end
            T2: begin
                load_pc = 1'b1;
                state_d = T3;
            end
            T3: begin
                load_ir = 1'b1;
                state_d = T4;
            end
            T4: begin
                state_d = T5;
                if (is_alu) begin
                    load_w = 1'b1;
                end else if (is_goto) begin
                    load_pc   = 1'b1;
                    pc_src    = 1'b1;
                    pc_target = jump_addr;
                end else if (is_call) begin
                    // pc was already incremented in T2, so it is the return address.
                    load_pc   = 1'b1;
                    pc_src    = 1'b1;
                    pc_target = jump_addr;
                    push      = 1'b1;
                    sp_d      = sp_q + SP_W'(1);
                    if (depth_q == DEPTH_FULL) err_d = 1'b1;
                    else depth_d = depth_q + DEP_W'(1);
                end else if (is_ret) begin
                    load_pc = 1'b1;
                    pc_src  = 1'b1;
                    if (depth_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        pc_target = stack_q[top_idx];
                        sp_d      = top_idx;
                        depth_d   = depth_q - DEP_W'(1);
                    end
                end else if (!is_nop) begin
                    illegal = 1'b1;
                end
            end
            T5:   state_d = T6;
            T6:   state_d = go ? T1 : HALT;
            HALT: state_d = go ? T1 : HALT;
            default: state_d = T0;
        endcase
    end

    // A full stack wraps the pointer, so a push overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= T0;
            sp_q    <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            if (push) stack_q[sp_q] <= pc;
        end
    end

    assign halted    = (state_q == HALT);
    assign stk_err   = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a small datapath (PC, MAR, IR, W, ROM) around the DUT and an
// instruction-level reference model of program flow, W and the return stack.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [13:0] dp_ir;
    logic [10:0] dp_pc, dp_mar;
    logic [7:0]  dp_w;
    logic        load_mar, load_pc, pc_src, load_ir, load_w, halted, illegal, stk_err;
    logic [10:0] pc_target;
    logic [2:0]  state_dbg;

    logic [13:0] rom [2048];
    int          checks = 0;
    int          failures = 0;

    logic [10:0] m_pc;
    logic [7:0]  m_w;
    logic [10:0] m_stack [$];
    logic        m_err;

    always #5 clk = ~clk;

    instr_sequencer #(.PC_W(11), .IR_W(14), .STACK_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .ir(dp_ir), .pc(dp_pc),
        .load_mar(load_mar), .load_pc(load_pc), .pc_src(pc_src), .pc_target(pc_target),
        .load_ir(load_ir), .load_w(load_w), .halted(halted), .illegal(illegal),
        .stk_err(stk_err), .state_dbg(state_dbg)
    );

    function automatic logic [7:0] alu(input logic [13:0] w_ir, input logic [7:0] w);
        logic [7:0] k;
        k = w_ir[7:0];
        case (w_ir[13:8])
            6'b110000: return k;
            6'b111110: return w + k;
            6'b111100: return k - w;
            6'b111001: return w & k;
            6'b111000: return w | k;
            6'b111010: return w ^ k;
            default:   return w;
        endcase
    endfunction

    // 0 alu, 1 goto, 2 call, 3 return, 4 nop, 5 illegal
    function automatic int classify(input logic [13:0] w_ir);
        case (w_ir[13:8])
            6'b110000, 6'b111110, 6'b111100, 6'b111001, 6'b111000, 6'b111010: return 0;
            default: ;
        endcase
        if (w_ir[13:11] == 3'b101) return 1;
        if (w_ir[13:11] == 3'b100) return 2;
        if (w_ir == 14'h0008) return 3;
        if (w_ir == 14'h0000) return 4;
        return 5;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            dp_pc <= '0; dp_mar <= '0; dp_ir <= '0; dp_w <= '0;
        end else begin
            if (load_mar) dp_mar <= dp_pc;
            if (load_pc) dp_pc <= pc_src ? pc_target : dp_pc + 11'd1;
            if (load_ir) dp_ir <= rom[dp_mar];
            if (load_w) dp_w <= alu(dp_ir, dp_w);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {load_mar, load_pc, pc_src, load_ir, load_w, illegal, halted};
    endfunction

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = 14'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_strobes", 32'(strobes()), 32'd0);
        check("rst_stk_err", 32'(stk_err), 32'd0);
        rst = 1'b0;
        m_pc = '0; m_w = '0; m_err = 1'b0;
        m_stack.delete();
    endtask

    task automatic wait_t1();
        int n;
        n = 0;
        while (state_dbg !== 3'd1 && n < 16) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        check("reach_t1", 32'(state_dbg), 32'd1);
    endtask

    // Runs one instruction from T1 to T6, comparing each phase against the model.
    task automatic exec_one(input int step_at, input logic [2:0] exp_next);
        logic [13:0] iw;
        logic [10:0] npc, tgt;
        logic [6:0]  exp_vec;
        int          kind;
        logic        jump;
        wait_t1();
        iw   = rom[m_pc];
        kind = classify(iw);
        npc  = m_pc + 11'd1;
        jump = (kind == 1) || (kind == 2) || (kind == 3);
        if (kind == 3) tgt = (m_stack.size() == 0) ? 11'd0 : m_stack[$];
        else tgt = iw[10:0];
        for (int t = 1; t <= 6; t++) begin
            step = (t == step_at);
            check("phase", 32'(state_dbg), 32'(t));
            exp_vec = {t == 1, (t == 2) || (t == 4 && jump), t == 4 && jump, t == 3,
                       t == 4 && kind == 0, t == 4 && kind == 5, 1'b0};
            check("strobes", 32'(strobes()), 32'(exp_vec));
            if (t == 1) check("fetch_pc", 32'(dp_pc), 32'(m_pc));
            if (t == 4) check("ir_word", 32'(dp_ir), 32'(iw));
            if (t == 4 && jump) check("pc_target", 32'(pc_target), 32'(tgt));
            @(posedge clk); @(negedge clk);
        end
        step = 1'b0;
        m_pc = npc;
        case (kind)
            0: m_w = alu(iw, m_w);
            1: m_pc = tgt;
            2: begin
                m_stack.push_back(npc);
                if (m_stack.size() > 8) begin
                    void'(m_stack.pop_front());
                    m_err = 1'b1;
                end
                m_pc = tgt;
            end
            3: begin
                if (m_stack.size() == 0) m_err = 1'b1;
                else void'(m_stack.pop_back());
                m_pc = tgt;
            end
            default: ;
        endcase
        check("pc_after", 32'(dp_pc), 32'(m_pc));
        check("w_after", 32'(dp_w), 32'(m_w));
        check("stk_err", 32'(stk_err), 32'(m_err));
        check("next_state", 32'(state_dbg), 32'(exp_next));
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] alu_ops [6];
        alu_ops = '{6'h30, 6'h3E, 6'h3C, 6'h39, 6'h38, 6'h3A};

        // Straight-line ALU ops followed by a GOTO.
        clear_rom();
        rom[0] = 14'h3005; rom[1] = 14'h3E03; rom[2] = 14'h2805; rom[5] = 14'h3042;
        do_reset();
        run = 1'b1;
        exec_one(0, 3'd1);
        check("w_movlw", 32'(dp_w), 32'h05);
        exec_one(0, 3'd1);
        check("w_addlw", 32'(dp_w), 32'h08);
        exec_one(0, 3'd1);
        check("goto_pc", 32'(dp_pc), 32'd5);
        exec_one(0, 3'd1);
        check("w_after_goto", 32'(dp_w), 32'h42);

        // CALL then RETURN.
        clear_rom();
        rom[0] = 14'h2010; rom[16] = 14'h0008;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 3; i++) exec_one(0, 3'd1);
        check("call_ret_err", 32'(stk_err), 32'd0);

        // Nine nested calls overflow the stack.
        clear_rom();
        for (int i = 0; i < 9; i++) rom[i] = 14'h2000 | 14'(i + 1);
        rom[9] = 14'h0008;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 8; i++) exec_one(0, 3'd1);
        check("no_ovf_at_8", 32'(stk_err), 32'd0);
        exec_one(0, 3'd1);
        check("ovf_at_9", 32'(stk_err), 32'd1);
        exec_one(0, 3'd1);

        // RETURN on an empty stack.
        clear_rom();
        rom[0] = 14'h0008;
        do_reset();
        run = 1'b1;
        exec_one(0, 3'd1);
        check("underflow_err", 32'(stk_err), 32'd1);

        // Illegal opcode.
        clear_rom();
        rom[0] = 14'h3FFF;
        do_reset();
        run = 1'b1;
        exec_one(0, 3'd1);

        // Halt and single-step.
        clear_rom();
        rom[0] = 14'h3007; rom[1] = 14'h3E01; rom[2] = 14'h3E01;
        do_reset();
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("halt_state", 32'(state_dbg), 32'd7);
            check("halt_strobes", 32'(strobes()), 32'h01);
            @(posedge clk); @(negedge clk);
        end
        step = 1'b1;
        @(posedge clk); @(negedge clk);
        exec_one(3, 3'd7);
        check("w_after_step", 32'(dp_w), 32'h07);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("still_halted", 32'(state_dbg), 32'd7);
        step = 1'b1;
        @(posedge clk); @(negedge clk);
        exec_one(6, 3'd1);
        exec_one(0, 3'd7);
        check("w_two_steps", 32'(dp_w), 32'h09);

        // Reset asserted in T3.
        clear_rom();
        rom[0] = 14'h3011;
        do_reset();
        run = 1'b1;
        wait_t1();
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check("mid_t3", 32'(state_dbg), 32'd3);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst_state", 32'(state_dbg), 32'd0);
        check("midrst_strobes", 32'(strobes()), 32'd0);
        check("midrst_w", 32'(dp_w), 32'd0);
        rst = 1'b0; run = 1'b0;

        // Random programs against the instruction-level model.
        clear_rom();
        for (int a = 0; a < 64; a++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rom[a] = {alu_ops[$urandom_range(0, 5)], 8'($urandom)};
                4: rom[a] = 14'h0000;
                5: rom[a] = {3'b101, 11'($urandom_range(0, 63))};
                6, 7: rom[a] = {3'b100, 11'($urandom_range(0, 63))};
                8: rom[a] = 14'h0008;
                default: rom[a] = 14'($urandom_range(1, 7));
            endcase
        end
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 40; i++) exec_one(0, 3'd1);
        run = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
